// File: rtl/p_mem_arbiter.sv
// Shares one physical-memory port between the I-cache and D-cache.
// Round-robin arbitration, grant-time latching of the command, response routing, contention counter.
module p_mem_arbiter #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,
    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp,
    output logic [CNT_WIDTH-1:0]  contention_count
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t state, state_nxt;
    logic   last_grant;
    logic   op_write;
    logic   i_req, d_req;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

    // State register plus the grant-time latch of address, data and op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= GRANT_D;
            op_write    <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == SERVE_I) begin
                mem_address <= i_pmem_address;
                op_write    <= 1'b0;
                last_grant  <= GRANT_I;
            end else if (state == IDLE && state_nxt == SERVE_D) begin
                mem_address <= d_pmem_address;
                mem_wdata   <= d_pmem_wdata;
                op_write    <= d_pmem_write;
                last_grant  <= GRANT_D;
            end
        end
    end

    // Leaving SERVE_x always goes through IDLE, so a requester that drops
    // its request on the edge after resp is never granted a second time.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_req && d_req)
                    state_nxt = (last_grant == GRANT_D) ? SERVE_I : SERVE_D;
                else if (i_req)
                    state_nxt = SERVE_I;
                else if (d_req)
                    state_nxt = SERVE_D;
            end
            SERVE_I, SERVE_D: if (mem_resp) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_read    = (state != IDLE) && !op_write;
        mem_write   = (state != IDLE) &&  op_write;
        i_pmem_resp = (state == SERVE_I) && mem_resp;
        d_pmem_resp = (state == SERVE_D) && mem_resp;
    end

    assign i_pmem_rdata = mem_rdata;
    assign d_pmem_rdata = mem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            contention_count <= '0;
        else if ((state == SERVE_I && d_req) || (state == SERVE_D && i_req))
            contention_count <= contention_count + CNT_WIDTH'(1);
    end

endmodule

// File: doc/p_mem_arbiter.md
Name: p_mem_arbiter

Overview:
- Arbitrates the single shared physical-memory (L2/burst-adapter) port between the pipelined I-cache and the D-cache.
- Grants the port to one requester at a time using round-robin tie-break, and latches the address, write data and operation at grant.
- Routes the memory response back to the granted cache only.
- Sits between both cache controllers and the memory interface; counts contention cycles for performance analysis.

Parameters:
LINE_WIDTH, 256, cacheline data width in bits
ADDR_WIDTH, 32, physical address width
CNT_WIDTH, 32, contention counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
i_pmem_read  in  1  I-cache line-fill request
i_pmem_address  in  ADDR_WIDTH  I-cache line address
i_pmem_rdata  out  LINE_WIDTH  line data to I-cache
i_pmem_resp  out  1  I-cache request complete
d_pmem_read  in  1  D-cache line-fill request
d_pmem_write  in  1  D-cache writeback request
d_pmem_address  in  ADDR_WIDTH  D-cache line address
d_pmem_wdata  in  LINE_WIDTH  D-cache writeback data
d_pmem_rdata  out  LINE_WIDTH  line data to D-cache
d_pmem_resp  out  1  D-cache request complete
mem_read  out  1  read to memory
mem_write  out  1  write to memory
mem_address  out  ADDR_WIDTH  latched granted address
mem_wdata  out  LINE_WIDTH  latched write data
mem_rdata  in  LINE_WIDTH  memory read data
mem_resp  in  1  memory done
contention_count  out  CNT_WIDTH  cycles a requester waited while the other held the port

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous and active-high.
- Reset values: state=IDLE, last_grant=DCACHE, mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, both resp=0, contention_count=0.
- A reset asserted mid-transaction drops mem_read/mem_write immediately. No response is issued for that transaction.
- States:
  - IDLE: no memory command driven.
  - SERVE_I: I-cache holds the port.
  - SERVE_D: D-cache holds the port.
- IDLE transitions:
  - Only i_pmem_read set -> SERVE_I.
  - Only a D request set (read or write) -> SERVE_D.
  - Both set -> grant the side opposite last_grant, so the I-cache wins the first tie after reset.
  - Neither set -> stay in IDLE.
- Grant registration, on the edge leaving IDLE:
  - Latch address into mem_address.
  - Latch d_pmem_wdata into mem_wdata (D grant only).
  - Latch op = write if d_pmem_write, else read. If d_pmem_read and d_pmem_write are both high, write wins.
  - Update last_grant.
- Arbitration latency: exactly 1 cycle. mem_read/mem_write are Moore outputs of state+op and assert the cycle after the request is first seen in IDLE.
- SERVE_x:
  - Hold the command and latched fields stable until mem_resp.
  - In the mem_resp cycle, x_pmem_resp=1 combinationally and x_pmem_rdata=mem_rdata.
  - Next state is IDLE. There is one mandatory idle cycle between transactions, so a requester's deasserting request is never re-granted.
- Non-granted outputs:
  - The non-owner's resp is always 0.
  - i_pmem_rdata and d_pmem_rdata both pass mem_rdata continuously; only resp qualifies them.
- Requester contract: hold request and address stable until resp; deassert on the edge after resp. Requests deasserted before grant are simply not granted.
- Requests arriving during SERVE_x from the other side wait. contention_count increments by 1 every cycle in SERVE_x with the other side's request high. It wraps at 2^CNT_WIDTH.
- mem_resp seen in IDLE is ignored: no resp, no state change.

Test Plan:
1. I-only read, addr 0x0000_1000, mem_resp after 4 cycles with rdata=0xA5..A5 -> mem_read high cycles 1-5; i_pmem_resp pulses 1 cycle with matching data; d_pmem_resp stays 0.
2. D writeback, addr 0x0000_2040, wdata=0x1234..; requester changes d_pmem_wdata after grant -> mem_write=1, mem_wdata keeps the grant-time value; d_pmem_resp pulses on mem_resp.
3. I read and D read both raised in the same cycle after reset -> I served first, then D; contention_count = cycles D waited (e.g. 5 for a 4-cycle memory latency); second tie goes to I again only if D was last.
4. Both continuously requesting for 4 transactions -> grants alternate I, D, I, D with exactly one IDLE cycle between each.
5. rst asserted mid-SERVE_D with mem_write high -> mem_write drops without waiting for a clock; no d_pmem_resp; after release, state=IDLE and contention_count=0.
6. Stray mem_resp in IDLE plus d_pmem_read and d_pmem_write both high -> no resp generated; the subsequent D grant issues mem_write=1, mem_read=0.
